// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multicycle MIPS control FSM (lw, sw, R-type, beq, j) with mem_ready stalls and trap.
// Define MIPS_CTRL_ADDI_EN to add addi support (ADDI_EX/ADDI_WB states).
module mips_multicycle_ctrl #(
  parameter int COUNT_W = 32,
  parameter logic [5:0] LW_OP = 6'b100011,
  parameter logic [5:0] SW_OP = 6'b101011,
  parameter logic [5:0] RT_OP = 6'b000000,
  parameter logic [5:0] BEQ_OP = 6'b000100,
  parameter logic [5:0] J_OP = 6'b000010
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic [1:0]         ALUOp,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IorD,
  output logic               RegWrite,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               ALUSrcA,
  output logic               illegal_op,
  output logic [3:0]         state_dbg,
  output logic [COUNT_W-1:0] instr_count
);
`ifdef MIPS_CTRL_ADDI_EN
  localparam logic [5:0] ADDI_OP = 6'b001000;
`endif
  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEMADDR  = 4'd3,
    MEMREAD  = 4'd4,
    MEMWB    = 4'd5,
    MEMWRITE = 4'd6,
    EXECUTE  = 4'd7,
    RWB      = 4'd8,
    BRANCH   = 4'd9,
    JUMP     = 4'd10,
`ifdef MIPS_CTRL_ADDI_EN
    ADDI_EX  = 4'd11,
    ADDI_WB  = 4'd12,
`endif
    TRAP     = 4'd15
  } state_t;
  state_t state, next;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      instr_count <= '0;
    end else begin
      state <= next;
      if (state == FETCH && mem_ready) instr_count <= instr_count + COUNT_W'(1);
    end
  end
  assign state_dbg = state;
  // Reset forces state to IDLE asynchronously, and IDLE decodes to all-zero controls.
  always_comb begin
    next = TRAP;
    ALUOp = 2'b00;
    ALUSrcB = 2'b00;
    PCSource = 2'b00;
    RegDst = 1'b0;
    MemtoReg = 1'b0;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    IorD = 1'b0;
    RegWrite = 1'b0;
    IRWrite = 1'b0;
    PCWrite = 1'b0;
    PCWriteCond = 1'b0;
    ALUSrcA = 1'b0;
    illegal_op = 1'b0;
    case (state)
      IDLE: next = FETCH;
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        next = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        next = (opcode == LW_OP || opcode == SW_OP) ? MEMADDR :
               (opcode == RT_OP)  ? EXECUTE :
               (opcode == BEQ_OP) ? BRANCH :
               (opcode == J_OP)   ? JUMP :
`ifdef MIPS_CTRL_ADDI_EN
               (opcode == ADDI_OP) ? ADDI_EX :
`endif
               TRAP;
      end
      MEMADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        next = (opcode == LW_OP) ? MEMREAD : (opcode == SW_OP) ? MEMWRITE : TRAP;
      end
      MEMREAD: begin
        MemRead = 1'b1;
        IorD = 1'b1;
        next = mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        next = FETCH;
      end
      MEMWRITE: begin
        MemWrite = 1'b1;
        IorD = 1'b1;
        next = mem_ready ? FETCH : MEMWRITE;
      end
      EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp = 2'b10;
        next = RWB;
      end
      RWB: begin
        RegDst = 1'b1;
        RegWrite = 1'b1;
        next = FETCH;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp = 2'b01;
        PCWriteCond = 1'b1;
        PCSource = 2'b01;
        next = FETCH;
      end
      JUMP: begin
        PCWrite = 1'b1;
        PCSource = 2'b10;
        next = FETCH;
      end
`ifdef MIPS_CTRL_ADDI_EN
      ADDI_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        next = ADDI_WB;
      end
      ADDI_WB: begin
        RegWrite = 1'b1;
        next = FETCH;
      end
`endif
      TRAP: begin
        illegal_op = 1'b1;
        next = TRAP;
      end
      default: next = TRAP;
    endcase
  end
endmodule
